// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions.
// Holds the data width, the FIFO entry width and the level/pointer width helper.
// Optional feature macro: UART_RX_FIFO_PERR_EN. When it is defined, each FIFO
// entry carries the parity-error tag as bit 8; otherwise entries are bytes only.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

`ifdef UART_RX_FIFO_PERR_EN
  localparam int unsigned RX_ENTRY_W = UART_DATA_W + 1;  // {perr, byte}
`else
  localparam int unsigned RX_ENTRY_W = UART_DATA_W;
`endif

  // Counter width able to hold 0..depth inclusive (depth is a power of two).
  function automatic int unsigned lvl_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Port bundle between the UART receiver / APB read path and the RX FIFO.
// master: drives wr_en, wr_data, wr_perr, rd_en, flush, ovf_clr; observes status.
// slave : the FIFO; drives rd_data, rd_perr, rx_ready, full, thresh, level, overflow.
// Optional feature macro: UART_RX_FIFO_PERR_EN (affects only FIFO internals).
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned LW = lvl_w(DEPTH);

  logic                   wr_en;
  logic [UART_DATA_W-1:0] wr_data;
  logic                   wr_perr;
  logic                   rd_en;
  logic                   flush;
  logic                   ovf_clr;
  logic [UART_DATA_W-1:0] rd_data;
  logic                   rd_perr;
  logic                   rx_ready;
  logic                   full;
  logic                   thresh;
  logic [LW-1:0]          level;
  logic                   overflow;

  modport master (
    output wr_en, wr_data, wr_perr, rd_en, flush, ovf_clr,
    input  rd_data, rd_perr, rx_ready, full, thresh, level, overflow
  );

  modport slave (
    input  wr_en, wr_data, wr_perr, rd_en, flush, ovf_clr,
    output rd_data, rd_perr, rx_ready, full, thresh, level, overflow
  );

endinterface

// File: rtl/uart_rx_fifo_ram.sv
// Simple dual-port storage for the RX FIFO.
// Ports: CLK; write port we/waddr/wdata (synchronous); read port raddr/rdata
// (asynchronous). No reset so that it maps onto distributed RAM.
// Optional feature macro: UART_RX_FIFO_PERR_EN (sets WIDTH via the top).
module uart_rx_fifo_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the APB register file.
// Ports: CLK, RESET (synchronous, active-high); bus (uart_rx_fifo_if.slave):
//   wr_en/wr_data/wr_perr push strobe, rd_en pop strobe, flush, ovf_clr;
//   rd_data/rd_perr show-ahead head entry (0 when empty), rx_ready, full,
//   thresh, level, sticky overflow.
// Optional feature macro: UART_RX_FIFO_PERR_EN stores and returns the parity tag;
// without it wr_perr is ignored and rd_perr is 0.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned THRESH = 8,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input logic          CLK,
  input logic          RESET,
  uart_rx_fifo_if.slave bus
);

  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LvlFull   = LW'(DEPTH);
  localparam logic [LW-1:0] LvlThresh = LW'(THRESH);

  logic [AW-1:0]         wptr_q, rptr_q;
  logic [LW-1:0]         level_q;
  logic                  ovf_q;
  logic                  is_empty, is_full;
  logic                  do_pop, do_push, drop;
  logic [RX_ENTRY_W-1:0] wentry, rentry;

  assign is_empty = (level_q == '0);
  assign is_full  = (level_q == LvlFull);

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign do_pop  = bus.rd_en && !is_empty;
  assign do_push = bus.wr_en && (!is_full || do_pop);
  assign drop    = bus.wr_en && is_full && !do_pop;

`ifdef UART_RX_FIFO_PERR_EN
  assign wentry = {bus.wr_perr, bus.wr_data};
`else
  logic unused_wr_perr;
  assign unused_wr_perr = bus.wr_perr;
  assign wentry = bus.wr_data;
`endif

  uart_rx_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (RX_ENTRY_W),
    .AW    (AW)
  ) u_ram (
    .CLK   (CLK),
    .we    (do_push && !bus.flush),
    .waddr (wptr_q),
    .wdata (wentry),
    .raddr (rptr_q),
    .rdata (rentry)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (bus.flush) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        level_q <= '0;
      end else begin
        if (do_push) wptr_q <= wptr_q + 1'b1;
        if (do_pop)  rptr_q <= rptr_q + 1'b1;
        if (do_push && !do_pop)      level_q <= level_q + 1'b1;
        else if (do_pop && !do_push) level_q <= level_q - 1'b1;
      end
      // A drop in a flush cycle is discarded along with the push; set beats clear.
      if (drop && !bus.flush) ovf_q <= 1'b1;
      else if (bus.ovf_clr)   ovf_q <= 1'b0;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_perr = 1'b0;
    if (!is_empty) begin
      bus.rd_data = rentry[UART_DATA_W-1:0];
`ifdef UART_RX_FIFO_PERR_EN
      bus.rd_perr = rentry[UART_DATA_W];
`endif
    end
  end

  assign bus.rx_ready = !is_empty;
  assign bus.full     = is_full;
  assign bus.thresh   = (level_q >= LvlThresh);
  assign bus.level    = level_q;
  assign bus.overflow = ovf_q;

endmodule
